// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: PC, imem req/ack, 1-entry skid buffer toward decode,
// branch-redirect flush with in-flight request drain, and HLT stop.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_instr,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_next,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    STALL = 3'd1,
    DRAIN = 3'd2,
    HPEND = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t      state_r;
  logic [15:0] pc_r;
  logic [15:0] req_addr_r;
  logic [15:0] out_instr_r;
  logic [15:0] out_pc_r;
  logic [15:0] out_pc_next_r;
  logic        out_valid_r;
  logic [15:0] skid_instr_r;
  logic [15:0] skid_pc_r;
  logic        skid_valid_r;
  logic        halted_r;

  logic        ack_s;
  logic        consume_s;
  logic        push_s;
  logic        push_out_s;
  logic        hlt_word_s;
  logic        hlt_take_s;
  logic        skid_hlt_s;

  // A DRAIN request keeps the address captured at redirect time so it never changes before ack.
  assign imem_req   = ~rst & ((state_r == FETCH) | (state_r == DRAIN));
  assign imem_addr  = (state_r == DRAIN) ? req_addr_r : pc_r;

  assign ack_s      = imem_req & imem_ack;
  assign consume_s  = out_valid_r & id_ready;
  assign push_s     = (state_r == FETCH) & ack_s & ~redirect;
  assign push_out_s = push_s & (~out_valid_r | consume_s);
  assign hlt_word_s = (imem_data[15:12] == 4'hF);
  assign hlt_take_s = consume_s & (out_instr_r[15:12] == 4'hF);
  assign skid_hlt_s = (skid_instr_r[15:12] == 4'hF);

  assign id_valid   = out_valid_r;
  assign id_instr   = out_instr_r;
  assign id_pc      = out_pc_r;
  assign id_pc_next = out_pc_next_r;
  assign halted     = halted_r;

  // Sequencer state, PC and the output/skid instruction buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= FETCH;
      pc_r          <= RESET_PC;
      req_addr_r    <= RESET_PC;
      out_instr_r   <= 16'h0000;
      out_pc_r      <= 16'h0000;
      out_pc_next_r <= 16'h0002;
      out_valid_r   <= 1'b0;
      skid_instr_r  <= 16'h0000;
      skid_pc_r     <= 16'h0000;
      skid_valid_r  <= 1'b0;
      halted_r      <= 1'b0;
    end else if (state_r == HALT) begin
      state_r <= HALT;
    end else if (redirect) begin
      // Redirect outranks everything, including a same-cycle HLT acceptance.
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
      pc_r         <= redirect_pc;
      case (state_r)
        FETCH: begin
          if (ack_s) begin
            state_r <= FETCH;
          end else begin
            req_addr_r <= pc_r;
            state_r    <= DRAIN;
          end
        end
        DRAIN:   state_r <= ack_s ? FETCH : DRAIN;
        default: state_r <= FETCH;
      endcase
    end else begin
      if (push_out_s) begin
        out_instr_r   <= imem_data;
        out_pc_r      <= pc_r;
        out_pc_next_r <= pc_r + 16'd2;
        out_valid_r   <= 1'b1;
      end else if (consume_s && skid_valid_r) begin
        out_instr_r   <= skid_instr_r;
        out_pc_r      <= skid_pc_r;
        out_pc_next_r <= skid_pc_r + 16'd2;
        out_valid_r   <= 1'b1;
        skid_valid_r  <= 1'b0;
      end else if (consume_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end

      if (push_s && !push_out_s) begin
        skid_instr_r <= imem_data;
        skid_pc_r    <= pc_r;
        skid_valid_r <= 1'b1;
      end

      if (push_s) begin
        pc_r <= pc_r + 16'd2;
      end

      case (state_r)
        FETCH: begin
          if (push_s && hlt_word_s) begin
            state_r <= HPEND;
          end else if (push_s && !push_out_s) begin
            state_r <= STALL;
          end else begin
            state_r <= FETCH;
          end
        end
        STALL: begin
          if (consume_s && skid_valid_r) begin
            state_r <= skid_hlt_s ? HPEND : FETCH;
          end else begin
            state_r <= STALL;
          end
        end
        DRAIN:   state_r <= ack_s ? FETCH : DRAIN;
        HPEND: begin
          if (hlt_take_s) begin
            state_r  <= HALT;
            halted_r <= 1'b1;
          end else begin
            state_r <= HPEND;
          end
        end
        default: state_r <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an in-order expected-PC stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic [15:0] id_pc_next;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halted;

  logic        d2_req;
  logic [15:0] d2_addr;
  logic        d2_ack;
  logic [15:0] d2_data;
  logic        d2_valid;
  logic        d2_ready;
  logic [15:0] d2_instr;
  logic [15:0] d2_pc;
  logic [15:0] d2_pc_next;
  logic        d2_redirect;
  logic [15:0] d2_redirect_pc;
  logic        d2_halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic        hlt_en;
  logic [15:0] hlt_addr;
  int          lat_min;
  int          lat_max;
  int          cnt;
  int          cur_lat;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_next(id_pc_next), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );

  fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(d2_req), .imem_addr(d2_addr), .imem_ack(d2_ack), .imem_data(d2_data),
    .id_valid(d2_valid), .id_ready(d2_ready), .id_instr(d2_instr), .id_pc(d2_pc),
    .id_pc_next(d2_pc_next), .redirect(d2_redirect), .redirect_pc(d2_redirect_pc),
    .halted(d2_halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] gen(input logic [15:0] a);
    return {1'b0, a[3:1], a[12:1]};
  endfunction

  assign imem_data      = (hlt_en && imem_addr == hlt_addr) ? 16'hF000 : gen(imem_addr);
  assign d2_data        = gen(d2_addr);
  assign d2_ack         = 1'b1;
  assign d2_ready       = 1'b1;
  assign d2_redirect    = 1'b0;
  assign d2_redirect_pc = 16'h0000;

  // Memory responder: ack after cur_lat wait cycles of a held request.
  always @(negedge clk) begin
    if (imem_req) begin
      if (cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
      if (cnt >= cur_lat) begin
        imem_ack = 1'b1;
        cnt = 0;
      end else begin
        imem_ack = 1'b0;
        cnt = cnt + 1;
      end
    end else begin
      imem_ack = 1'b0;
      cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Reset, then release; returns at the sample point of the first cycle after reset.
  task automatic start(input int lmin, input int lmax);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b1;
    hlt_en = 1'b0; hlt_addr = 16'h0000; lat_min = lmin; lat_max = lmax;
    step(); step();
    step(); rst = 1'b0;
    sample();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b1;
    hlt_en = 1'b0; hlt_addr = 16'h0000; lat_min = 0; lat_max = 0;
    step(); step(); sample();
    n_checks++;
    if ({imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted} !==
        {1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0002, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: req=%b addr=%h v=%b instr=%h pc=%h pcn=%h h=%b, required 0 0000 0 0000 0000 0002 0",
               imem_req, imem_addr, id_valid, id_instr, id_pc, id_pc_next, halted);
    end
    n_checks++;
    if ({d2_req, d2_addr, d2_valid, d2_halted} !== {1'b0, 16'hFFFE, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state_pc_fffe: req=%b addr=%h v=%b h=%b, required 0 fffe 0 0",
               d2_req, d2_addr, d2_valid, d2_halted);
    end
    step(); rst = 1'b0; sample();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL first_request: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [15:0] e;
    start(0, 0);
    for (int k = 0; k < 6; k++) begin
      step(); sample();
      e = 16'(2 * k);
      n_checks++;
      if ({id_valid, id_pc, id_instr, id_pc_next} !== {1'b1, e, gen(e), e + 16'd2}) begin
        n_fail++;
        $display("FAIL zero_wait[%0d]: v=%b pc=%h instr=%h pcn=%h, required 1 %h %h %h",
                 k, id_valid, id_pc, id_instr, id_pc_next, e, gen(e), e + 16'd2);
      end
      if (k == 0) begin
        n_checks++;
        if ({d2_valid, d2_pc, d2_instr, d2_pc_next, d2_addr} !==
            {1'b1, 16'hFFFE, gen(16'hFFFE), 16'h0000, 16'h0000}) begin
          n_fail++;
          $display("FAIL pc_wrap_first: v=%b pc=%h instr=%h pcn=%h addr=%h, required 1 fffe %h 0000 0000",
                   d2_valid, d2_pc, d2_instr, d2_pc_next, d2_addr, gen(16'hFFFE));
        end
      end else if (k == 1) begin
        n_checks++;
        if ({d2_valid, d2_pc, d2_pc_next} !== {1'b1, 16'h0000, 16'h0002}) begin
          n_fail++;
          $display("FAIL pc_wrap_second: v=%b pc=%h pcn=%h, required 1 0000 0002",
                   d2_valid, d2_pc, d2_pc_next);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] bp_pc [8];
    logic        bp_req [8];
    logic [15:0] bp_addr [8];
    logic [15:0] a;
    bp_pc   = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h2, 16'h4};
    bp_req  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bp_addr = '{16'h2, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4, 16'h6};
    start(0, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      id_ready = (i < 5) ? 1'b0 : 1'b1;
      sample();
      a = imem_req ? imem_addr : 16'h0000;
      n_checks++;
      if ({id_valid, id_pc, id_instr, imem_req, a} !==
          {1'b1, bp_pc[i], gen(bp_pc[i]), bp_req[i], bp_addr[i]}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: v=%b pc=%h instr=%h req=%b addr=%h, required 1 %h %h %b %h",
                 i, id_valid, id_pc, id_instr, imem_req, a, bp_pc[i], gen(bp_pc[i]), bp_req[i], bp_addr[i]);
      end
    end
  endtask

  task automatic test_redirect_drain();
    logic found;
    found = 1'b0;
    start(2, 2);
    for (int i = 0; i < 40 && !found; i++) begin
      step(); sample();
      if (imem_req && imem_addr == 16'h0006) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drain_wait: request for 0006 seen=%b, required 1", found);
    end else begin
      step(); redirect = 1'b1; redirect_pc = 16'h0040; sample();
      for (int i = 0; i < 5; i++) begin
        if (i == 1) begin
          step(); redirect = 1'b0; sample();
        end else if (i > 1) begin
          step(); sample();
        end
        n_checks++;
        if ({imem_req, imem_addr, id_valid} !== {1'b1, (i < 2) ? 16'h0006 : 16'h0040, 1'b0}) begin
          n_fail++;
          $display("FAIL drain[%0d]: req=%b addr=%h v=%b, required 1 %h 0",
                   i, imem_req, imem_addr, id_valid, (i < 2) ? 16'h0006 : 16'h0040);
        end
      end
      step(); sample();
      n_checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 16'h0040, gen(16'h0040)}) begin
        n_fail++;
        $display("FAIL drain_deliver: v=%b pc=%h instr=%h, required 1 0040 %h",
                 id_valid, id_pc, id_instr, gen(16'h0040));
      end
    end
  endtask

  task automatic test_redirect_flush(input int at);
    start(0, 0);
    step(); id_ready = 1'b0;
    if (at == 0) begin
      redirect = 1'b1; redirect_pc = 16'h0080;
    end
    sample();
    n_checks++;
    if ({id_valid, imem_req} !== {1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL flush%0d_setup_ack: v=%b req=%b, required 1 1", at, id_valid, imem_req);
    end
    if (at == 1) begin
      step(); redirect = 1'b1; redirect_pc = 16'h0080; sample();
      n_checks++;
      if ({id_valid, imem_req} !== {1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL flush1_setup_skid: v=%b req=%b, required 1 0", id_valid, imem_req);
      end
    end
    step(); redirect = 1'b0; id_ready = 1'b1; sample();
    n_checks++;
    if ({id_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0080}) begin
      n_fail++;
      $display("FAIL flush%0d_refetch: v=%b req=%b addr=%h, required 0 1 0080",
               at, id_valid, imem_req, imem_addr);
    end
    for (int i = 0; i < 2; i++) begin
      step(); sample();
      n_checks++;
      if ({id_valid, id_pc, id_instr} !== {1'b1, 16'(16'h0080 + 2 * i), gen(16'(16'h0080 + 2 * i))}) begin
        n_fail++;
        $display("FAIL flush%0d_deliver[%0d]: v=%b pc=%h instr=%h, required 1 %h %h", at, i,
                 id_valid, id_pc, id_instr, 16'(16'h0080 + 2 * i), gen(16'(16'h0080 + 2 * i)));
      end
    end
  endtask

  task automatic test_halt();
    start(0, 0);
    hlt_en = 1'b1; hlt_addr = 16'h0004;
    step(); sample();
    step(); sample();
    n_checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0004}) begin
      n_fail++;
      $display("FAIL halt_fetch: req=%b addr=%h, required 1 0004", imem_req, imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      id_ready = (i == 2) ? 1'b1 : 1'b0;
      sample();
      n_checks++;
      if ({id_valid, id_instr, id_pc, imem_req, halted} !== {1'b1, 16'hF000, 16'h0004, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL halt_pending[%0d]: v=%b instr=%h pc=%h req=%b h=%b, required 1 f000 0004 0 0",
                 i, id_valid, id_instr, id_pc, imem_req, halted);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      redirect = (i == 1) ? 1'b1 : 1'b0;
      redirect_pc = 16'h0010;
      sample();
      n_checks++;
      if ({id_valid, imem_req, halted} !== {1'b0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL halted[%0d]: v=%b req=%b h=%b, required 0 0 1", i, id_valid, imem_req, halted);
      end
    end
    redirect = 1'b0;
  endtask

  task automatic test_hlt_redirect(input logic rdy);
    start(0, 0);
    hlt_en = 1'b1; hlt_addr = 16'h0004;
    step(); sample();
    step(); sample();
    step(); id_ready = 1'b0; sample();
    n_checks++;
    if ({id_valid, id_instr} !== {1'b1, 16'hF000}) begin
      n_fail++;
      $display("FAIL hltredir%0b_setup: v=%b instr=%h, required 1 f000", rdy, id_valid, id_instr);
    end
    step(); id_ready = rdy; redirect = 1'b1; redirect_pc = 16'h0010; sample();
    step(); id_ready = 1'b1; redirect = 1'b0; sample();
    n_checks++;
    if ({halted, id_valid, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0010}) begin
      n_fail++;
      $display("FAIL hltredir%0b_refetch: h=%b v=%b req=%b addr=%h, required 0 0 1 0010",
               rdy, halted, id_valid, imem_req, imem_addr);
    end
    step(); sample();
    n_checks++;
    if ({halted, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, 16'h0010, gen(16'h0010)}) begin
      n_fail++;
      $display("FAIL hltredir%0b_deliver: h=%b v=%b pc=%h instr=%h, required 0 1 0010 %h",
               rdy, halted, id_valid, id_pc, id_instr, gen(16'h0010));
    end
  endtask

  // Random latency, back-pressure and redirects; decode must see an in-order PC stream
  // restarting at each redirect target, and a waiting request must never change.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic [15:0] prev_addr;
    logic        prev_req;
    logic        hold;
    logic [31:0] r;
    int          accepted;
    int          hold_err;
    exp_pc = 16'h0000; accepted = 0; hold_err = 0;
    start(0, 3);
    prev_req = imem_req; prev_addr = imem_addr;
    for (int i = 0; i < 1500; i++) begin
      step();
      hold = prev_req & ~imem_ack;
      id_ready = ($urandom_range(9, 0) < 7) ? 1'b1 : 1'b0;
      r = $urandom;
      redirect = (r[31:27] == 5'd0) ? 1'b1 : 1'b0;
      redirect_pc = {r[15:1], 1'b0};
      sample();
      if (hold && !(imem_req && imem_addr == prev_addr)) begin
        hold_err++;
        if (hold_err <= 3) begin
          n_checks++;
          n_fail++;
          $display("FAIL rand_req_hold[%0d]: req=%b addr=%h, required 1 %h", i, imem_req, imem_addr, prev_addr);
        end
      end
      prev_req = imem_req; prev_addr = imem_addr;
      if (id_valid && id_ready && !redirect) begin
        n_checks++;
        if ({id_pc, id_instr, id_pc_next} !== {exp_pc, gen(exp_pc), exp_pc + 16'd2}) begin
          n_fail++;
          $display("FAIL rand_deliver[%0d]: pc=%h instr=%h pcn=%h, required %h %h %h",
                   i, id_pc, id_instr, id_pc_next, exp_pc, gen(exp_pc), exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        accepted++;
      end
      if (redirect) exp_pc = redirect_pc;
    end
    redirect = 1'b0;
    n_checks++;
    if (accepted < 100) begin
      n_fail++;
      $display("FAIL rand_progress: accepted=%0d, required at least 100", accepted);
    end
  endtask

  initial begin
    cnt = 0; cur_lat = 0; imem_ack = 1'b0;
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_drain();
    test_redirect_flush(0);
    test_redirect_flush(1);
    test_halt();
    test_hlt_redirect(1'b0);
    test_hlt_redirect(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
    $fatal(1);
  end

endmodule
